pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB): keeps a shadow scoreboard of EX/MEM/WB
//  destinations, drives EX operand forwarding, inserts the 1-cycle load-use bubble and flushes
//  younger stages on a taken BEQ. Sits beside the control unit; decodes same opcodes from ID.
// PARAMETERS
//  RAW        5   register-address width; r0 hardwired zero, never a hazard source
//  CNT_W      16  width of stall/flush performance counters
// PORTS
//  clk           in   1      core clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  id_valid      in   1      ID stage holds a real instruction
//  id_ope        in   4      ID opcode: ADD 0000, ADI 0001, LW 0100, SW 0101, BEQ 1100, SUB 1111
//  id_cond       in   2      ID cond field (ADD writes only for 00/11)
//  id_rs1,id_rs2 in   RAW    ID source regs
//  id_rd         in   RAW    ID destination reg
//  mem_br_taken  in   1      BEQ compare result; meaningful only while MEM slot holds a BEQ
//  pc_stall      out  1      hold PC
//  ifid_stall    out  1      hold IF/ID register
//  idex_bubble   out  1      load NOP into ID/EX
//  ifid_flush, idex_flush, exmem_flush  out 1 each  clear those pipeline registers
//  fwd_a,fwd_b   out  2      EX operand select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB
//  stall_cnt     out  CNT_W  saturating count of load-use stalls
//  flush_cnt     out  CNT_W  saturating count of taken-branch flushes
// BEHAVIOUR
//  - Decode (ID): writes = SUB|ADI|LW|ADD&cond in{00,11}; reads rs1: all six ops; reads rs2:
//    ADD,SUB,SW,BEQ. Unknown opcode or id_valid=0 -> NOP (no reads, no writes).
//  - Shadow slots EX,MEM,WB each {v,rs1,rs2,rd,wr,ld,beq}; rd==0 forces wr=0.
//  - Per edge, normal: EX<=decoded ID, MEM<=EX, WB<=MEM. Stall: EX<=NOP, MEM<=EX, WB<=MEM.
//    Flush: EX<=NOP, MEM<=NOP, WB<=MEM.
//  - load_use = id reads r (r in rs1/rs2 per decode) && EX.v&EX.ld&EX.wr&&EX.rd==r.
//  - take = MEM.v&MEM.beq&mem_br_taken.
//  - Outputs combinational from slots+ID: take -> ifid/idex/exmem_flush=1, all stalls 0.
//    else load_use -> pc_stall=ifid_stall=idex_bubble=1. Flush has priority over stall.
//  - Forward (per EX source, only if EX reads it): MEM.wr&MEM.rd==src&!MEM.ld -> 10; else
//    WB.wr&WB.rd==src -> 01; else 00. MEM beats WB when both match.
//  - FSM (2-bit, registered): RUN; LDSTALL one cycle after a stall; BRFLUSH one cycle after
//    take. RUN->LDSTALL on load_use&!take; RUN/LDSTALL->BRFLUSH on take; LDSTALL->RUN else;
//    BRFLUSH->RUN unless take. In BRFLUSH, ID is treated as NOP (fetch post-flush bubble).
//  - Stall resolves in exactly 1 cycle: consumer enters EX as load reaches WB, fwd=01.
//  - Counters: +1 per stall cycle / per take cycle; hold at all-ones (no wrap).
//  - Reset (async, any time incl. mid-stall/flush): slots invalid, state RUN, counters 0;
//    all outputs 0 (fwd 00) while rst_n=0 and first cycle after release.
// STRUCTURE
//  - Shared package pipe_pkg: opcode localparams, FWD_RF/FWD_MEM/FWD_WB encodings,
//    FSM state enum, scoreboard slot struct.
//  - One sub-module: sat_counter (CNT_W, inc, async clear) instantiated twice.
// TESTING
//  1 LW r3 then ADD r4,r3,r2 -> one cycle pc_stall=ifid_stall=idex_bubble=1; next cycle fwd_a=01; stall_cnt=1.
//  2 ADD r5,r1,r2 then SUB r6,r5,r5 -> no stall; SUB in EX fwd_a=fwd_b=10.
//  3 ADD r7; NOP; ADD r8,r7,r7 -> fwd_a=fwd_b=01; ADD writing r0 then read r0 -> fwd 00.
//  4 BEQ in MEM, mem_br_taken=1 while load-use in ID -> 3 flushes=1, stalls=0; flush_cnt=1, stall_cnt=0.
//  5 rst_n low mid-stall -> all outputs 0 immediately; force counters near max -> hold 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard sequencer: opcodes, forward selects,
// sequencer states and the shadow-scoreboard slot with its ID decoder.
package pipe_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_SUB = 4'b1111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Slot register fields are sized for the widest supported register file.
  localparam int unsigned SLOT_AW = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_BRFLUSH = 2'b10
  } state_e;

  typedef struct packed {
    logic               v;
    logic               re1;
    logic               re2;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic [SLOT_AW-1:0] rd;
    logic               wr;
    logic               ld;
    logic               beq;
  } slot_t;

  localparam slot_t SLOT_NOP = '0;

  function automatic slot_t decode(input logic               valid,
                                   input logic [3:0]         ope,
                                   input logic [1:0]         cond,
                                   input logic [SLOT_AW-1:0] rs1,
                                   input logic [SLOT_AW-1:0] rs2,
                                   input logic [SLOT_AW-1:0] rd);
    slot_t s;
    s = SLOT_NOP;
    if (valid) begin
      case (ope)
        OP_ADD: begin s.v = 1'b1; s.re1 = 1'b1; s.re2 = 1'b1;
                      s.wr = (cond == 2'b00) || (cond == 2'b11); end
        OP_SUB: begin s.v = 1'b1; s.re1 = 1'b1; s.re2 = 1'b1; s.wr = 1'b1; end
        OP_ADI: begin s.v = 1'b1; s.re1 = 1'b1; s.wr = 1'b1; end
        OP_LW:  begin s.v = 1'b1; s.re1 = 1'b1; s.wr = 1'b1; s.ld = 1'b1; end
        OP_SW:  begin s.v = 1'b1; s.re1 = 1'b1; s.re2 = 1'b1; end
        OP_BEQ: begin s.v = 1'b1; s.re1 = 1'b1; s.re2 = 1'b1; s.beq = 1'b1; end
        default: s = SLOT_NOP;
      endcase
      if (s.v) begin
        s.rs1 = rs1;
        s.rs2 = rs2;
        s.rd  = rd;
      end
      // r0 is hardwired zero, so a write to it can never be a hazard source.
      if (rd == '0) s.wr = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard sequencer: shadow EX/MEM/WB scoreboard, EX forwarding,
// load-use bubble insertion and taken-BEQ flush, with stall/flush counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RAW   = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_ope,
  input  logic [1:0]       id_cond,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic [RAW-1:0]   id_rd,
  input  logic             mem_br_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t  id_s, ex_s, mem_s, wb_s;
  state_e state;
  logic   take, load_use, stall;

  // The fetch slot right after a flush holds a squashed instruction.
  assign id_s = decode(id_valid && (state != ST_BRFLUSH), id_ope, id_cond,
                       SLOT_AW'(id_rs1), SLOT_AW'(id_rs2), SLOT_AW'(id_rd));

  assign take     = mem_s.v && mem_s.beq && mem_br_taken;
  assign load_use = ex_s.v && ex_s.ld && ex_s.wr &&
                    ((id_s.re1 && (ex_s.rd == id_s.rs1)) ||
                     (id_s.re2 && (ex_s.rd == id_s.rs2)));
  assign stall    = load_use && !take;

  function automatic logic [1:0] fwd_sel(input logic re, input logic [SLOT_AW-1:0] src,
                                         input slot_t m, input slot_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (re) begin
      if (m.wr && (m.rd == src) && !m.ld) sel = FWD_MEM;
      else if (w.wr && (w.rd == src))     sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    ifid_flush  = take;
    idex_flush  = take;
    exmem_flush = take;
    pc_stall    = stall;
    ifid_stall  = stall;
    idex_bubble = stall;
    fwd_a       = fwd_sel(ex_s.re1, ex_s.rs1, mem_s, wb_s);
    fwd_b       = fwd_sel(ex_s.re2, ex_s.rs2, mem_s, wb_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s  <= SLOT_NOP;
      mem_s <= SLOT_NOP;
      wb_s  <= SLOT_NOP;
    end else if (take) begin
      ex_s  <= SLOT_NOP;
      mem_s <= SLOT_NOP;
      wb_s  <= mem_s;
    end else if (stall) begin
      ex_s  <= SLOT_NOP;
      mem_s <= ex_s;
      wb_s  <= mem_s;
    end else begin
      ex_s  <= id_s;
      mem_s <= ex_s;
      wb_s  <= mem_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:     if (take) state <= ST_BRFLUSH;
                    else if (load_use) state <= ST_LDSTALL;
        ST_LDSTALL: state <= take ? ST_BRFLUSH : ST_RUN;
        ST_BRFLUSH: state <= take ? ST_BRFLUSH : ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (take),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl; a narrow-counter twin checks saturation.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_ope;
  logic [1:0]  id_cond;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        mem_br_taken;
  logic        pc_stall, ifid_stall, idex_bubble;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc, s_ifs, s_bub, s_ff, s_fe, s_fm;
  logic [1:0]  s_fa, s_fb;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RAW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ope(id_ope), .id_cond(id_cond),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_br_taken(mem_br_taken),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.RAW(5), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ope(id_ope), .id_cond(id_cond),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_br_taken(mem_br_taken),
    .pc_stall(s_pc), .ifid_stall(s_ifs), .idex_bubble(s_bub),
    .ifid_flush(s_ff), .idex_flush(s_fe), .exmem_flush(s_fm),
    .fwd_a(s_fa), .fwd_b(s_fb), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct packed {
    logic       pc, ifs, bub, ff, fe, fm;
    logic [1:0] fa, fb;
  } exp_t;

  localparam exp_t E0      = 10'b000000_00_00;
  localparam exp_t E_STALL = 10'b111000_00_00;
  localparam exp_t E_FLUSH = 10'b000111_00_00;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic exp_t fw(input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    e    = E0;
    e.fa = a;
    e.fb = b;
    return e;
  endfunction

  function automatic exp_t observed();
    return {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int v, input int op, input int c, input int s1, input int s2,
                       input int d, input int bt, input exp_t e);
    id_valid     = 1'(v);
    id_ope       = 4'(op);
    id_cond      = 2'(c);
    id_rs1       = 5'(s1);
    id_rs2       = 5'(s2);
    id_rd        = 5'(d);
    mem_br_taken = 1'(bt);
    exp_q.push_back(e);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, 32'(observed()), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int v, input int op, input int c, input int s1,
                      input int s2, input int d, input int bt, input exp_t e);
    drive(v, op, c, s1, s2, d, bt, e);
    sample(tag);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b1; id_ope = OP_LW; id_cond = 2'b00;
    id_rs1 = 5'd1; id_rs2 = 5'd0; id_rd = 5'd3; mem_br_taken = 1'b1;
    #3;
    check("reset_out", 32'(observed()), 32'(E0));
    check("reset_cnt", {stall_cnt, flush_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load-use: one bubble, then the consumer takes the load from WB.
    step("t1_lw",    1, OP_LW,  0, 1, 0, 3, 0, E0);
    step("t1_stall", 1, OP_ADD, 0, 3, 2, 4, 0, E_STALL);
    check("t1_stall_cnt", 32'(stall_cnt), 1);
    step("t1_hold",  1, OP_ADD, 0, 3, 2, 4, 0, E0);
    step("t1_fwd",   0, 0,      0, 0, 0, 0, 0, fw(FWD_WB, FWD_RF));

    // ALU back-to-back: both operands from EX/MEM.
    step("t2_add",   1, OP_ADD, 0, 1, 2, 5, 0, E0);
    step("t2_sub",   1, OP_SUB, 0, 5, 5, 6, 0, E0);
    step("t2_fwd",   0, 0,      0, 0, 0, 0, 0, fw(FWD_MEM, FWD_MEM));

    // Distance-two from MEM/WB; r0 writes and cond=01 ADD never forward.
    step("t3_add7",   1, OP_ADD, 0, 1, 1, 7, 0, E0);
    step("t3_gap",    0, 0,      0, 0, 0, 0, 0, E0);
    step("t3_add8",   1, OP_ADD, 0, 7, 7, 8, 0, E0);
    step("t3_fwd_wb", 1, OP_ADD, 0, 1, 2, 0, 0, fw(FWD_WB, FWD_WB));
    step("t3_rd0",    1, OP_ADD, 0, 0, 0, 9, 0, E0);
    step("t3_r0_rd",  1, OP_ADD, 1, 1, 1, 10, 0, E0);
    step("t3_c01",    1, OP_SUB, 0, 10, 10, 11, 0, E0);
    step("t3_nowr",   0, 0,      0, 0, 0, 0, 1, E0);
    check("t3_flush_cnt", 32'(flush_cnt), 0);
    step("t3_idle",   0, 0,      0, 0, 0, 0, 0, E0);

    // Taken BEQ in MEM while a load-use sits in ID: flush wins.
    step("t4_beq",    1, OP_BEQ, 0, 1, 2, 0, 0, E0);
    step("t4_lw",     1, OP_LW,  0, 1, 0, 3, 0, E0);
    step("t4_take",   1, OP_ADD, 0, 3, 2, 4, 1, E_FLUSH);
    check("t4_cnts", {stall_cnt, flush_cnt}, {16'd1, 16'd1});
    step("t4_post",   1, OP_LW,  0, 1, 0, 12, 0, E0);
    step("t4_masked", 1, OP_ADD, 0, 12, 12, 13, 0, E0);
    step("t4_idle",   0, 0,      0, 0, 0, 0, 0, E0);

    // Asynchronous reset in the middle of a stall.
    step("t5_lw", 1, OP_LW, 0, 1, 0, 3, 0, E0);
    drive(1, OP_ADD, 0, 3, 2, 4, 0, E_STALL);
    sample("t5_stall");
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_out", 32'(observed()), 32'(E0));
    check("t5_rst_cnt", {stall_cnt, flush_cnt}, 32'h0);
    tick();
    check("t5_rst_hold", 32'(observed()), 32'(E0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_release", 32'(observed()), 32'(E0));
    step("t5_first", 1, OP_ADD, 0, 3, 2, 4, 0, E0);

    // Eight stalls: the 3-bit twin must stick at 7.
    for (int k = 0; k < 8; k++) begin
      step("sat_lw",    1, OP_LW,  0, 1, 0, 3, 0, (k == 0) ? E0 : fw(FWD_WB, FWD_RF));
      step("sat_stall", 1, OP_ADD, 0, 3, 2, 4, 0, E_STALL);
      step("sat_hold",  1, OP_ADD, 0, 3, 2, 4, 0, E0);
    end
    check("sat_main", 32'(stall_cnt), 8);
    check("sat_twin", 32'(s_stall_cnt), 7);

    // ADI ignores rs2; SW reads rs2.
    step("d_lw",  1, OP_LW,  0, 1, 0, 3, 0, fw(FWD_WB, FWD_RF));
    step("d_adi", 1, OP_ADI, 0, 1, 3, 5, 0, E0);
    step("d_lw6", 1, OP_LW,  0, 1, 0, 6, 0, E0);
    step("d_sw",  1, OP_SW,  0, 1, 6, 0, 0, E_STALL);
    check("d_cnt_main", 32'(stall_cnt), 9);
    check("d_cnt_twin", 32'(s_stall_cnt), 7);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
